// File: rtl/wb_data_sel_pipe.sv
// Writeback data select stage: picks one of NSRC sources (link address, extended
// load, or raw value), registers it with the write-back control behind a valid/ready handshake.
module wb_data_sel_pipe #(
  parameter int WIDTH       = 32,
  parameter int NSRC        = 4,
  parameter int SELW        = 2,
  parameter int LINK_SRC    = 2,
  parameter int LINK_OFFSET = 4,
  parameter int MEM_SRC     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_rdy,
  input  logic [SELW-1:0]       sel,
  input  logic [2:0]            ld_mode,
  input  logic [1:0]            addr_lo,
  input  logic                  wr_en_in,
  input  logic [4:0]            wr_addr_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_wr_en,
  output logic [4:0]            out_wr_addr,
  output logic                  stall_req
);

  // Byte/halfword extraction assumes WIDTH >= 32; addr_lo[0] is ignored for halves.
  function automatic logic [WIDTH-1:0] load_ext(input logic [WIDTH-1:0] w,
                                                input logic [2:0]       mode,
                                                input logic [1:0]       lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (mode)
      3'b001:  load_ext = {{(WIDTH-8){b[7]}}, b};
      3'b010:  load_ext = {{(WIDTH-8){1'b0}}, b};
      3'b011:  load_ext = {{(WIDTH-16){h[15]}}, h};
      3'b100:  load_ext = {{(WIDTH-16){1'b0}}, h};
      default: load_ext = w;
    endcase
  endfunction

  logic [SELW-1:0]  sel_eff;
  logic [WIDTH-1:0] src_sel;
  logic             src_ok;
  logic             capture;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_addr_q, wr_addr_d;

  assign sel_eff = (32'(sel) < NSRC) ? sel : '0;

  always_comb begin
    src_sel = '0;
    src_ok  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_eff == SELW'(k)) begin
        src_sel = src_data[k*WIDTH +: WIDTH];
        src_ok  = src_rdy[k];
      end
    end
  end

  assign in_ready  = (!valid_q || out_ready) && !flush;
  assign capture   = in_valid && in_ready && src_ok;
  assign stall_req = in_valid && !flush && (!in_ready || !src_ok);

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    if (flush) begin
      valid_d = 1'b0;
      wr_en_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      wr_en_d   = wr_en_in && (wr_addr_in != 5'd0);
      wr_addr_d = wr_addr_in;
      if (sel_eff == SELW'(LINK_SRC))
        data_d = src_sel + WIDTH'(LINK_OFFSET);
      else if (sel_eff == SELW'(MEM_SRC))
        data_d = load_ext(src_sel, ld_mode, addr_lo);
      else
        data_d = src_sel;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      wr_en_d = 1'b0;
    end
  end

  // Output register; data is also reset so nothing reads back as X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_wr_en   = wr_en_q;
  assign out_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_wb_data_sel_pipe.sv
// Directed bench for wb_data_sel_pipe with default parameters.
module tb_wb_data_sel_pipe;
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] src_data;
  logic [3:0]   src_rdy;
  logic [1:0]   sel;
  logic [2:0]   ld_mode;
  logic [1:0]   addr_lo;
  logic         wr_en_in;
  logic [4:0]   wr_addr_in;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_wr_en;
  logic [4:0]   out_wr_addr;
  logic         stall_req;

  int total = 0;
  int bad   = 0;

  wb_data_sel_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .src_rdy(src_rdy), .sel(sel), .ld_mode(ld_mode),
    .addr_lo(addr_lo), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [31:0] v);
    src_data[k*32 +: 32] = v;
  endtask

  // Capture one entry through sel/ld_mode/addr_lo and check the registered data.
  task automatic cap(input string tag, input logic [1:0] s, input logic [2:0] m,
                     input logic [1:0] lo, input logic [31:0] exp);
    sel = s; ld_mode = m; addr_lo = lo; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk(tag, out_data, exp);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; src_data = '0; src_rdy = 4'hF; sel = 2'd0;
    ld_mode = 3'd0; addr_lo = 2'd0; wr_en_in = 1'b0; wr_addr_in = 5'd0;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_wen", 32'(out_wr_en), 32'd0);
    chk("rst_waddr", 32'(out_wr_addr), 32'd0);
    #2 reset = 1'b0;

    // Link source: src2 + 4
    set_src(2, 32'h0000_3000); sel = 2'd2; in_valid = 1'b1; wr_en_in = 1'b1; wr_addr_in = 5'd5;
    #1;
    chk("link_inrdy", 32'(in_ready), 32'd1);
    chk("link_stall", 32'(stall_req), 32'd0);
    cyc();
    chk("link_vld", 32'(out_valid), 32'd1);
    chk("link_data", out_data, 32'h0000_3004);
    chk("link_wen", 32'(out_wr_en), 32'd1);
    chk("link_waddr", 32'(out_wr_addr), 32'd5);

    // Load extension on the memory source, back-to-back capture+drain
    set_src(1, 32'h1234_5680);
    cap("lb0",   2'd1, 3'b001, 2'd0, 32'hFFFF_FF80);
    cap("lbu0",  2'd1, 3'b010, 2'd0, 32'h0000_0080);
    cap("lh2",   2'd1, 3'b011, 2'd2, 32'h0000_1234);
    cap("lhu3",  2'd1, 3'b100, 2'd3, 32'h0000_1234);
    cap("lh0",   2'd1, 3'b011, 2'd0, 32'h0000_5680);
    cap("lb3",   2'd1, 3'b001, 2'd3, 32'h0000_0012);
    cap("lbu1",  2'd1, 3'b010, 2'd1, 32'h0000_0056);
    cap("word",  2'd1, 3'b000, 2'd1, 32'h1234_5680);
    cap("other", 2'd1, 3'b111, 2'd0, 32'h1234_5680);
    set_src(0, 32'hDEAD_BEEF);
    cap("src0",  2'd0, 3'b001, 2'd0, 32'hDEAD_BEEF);

    // Write to r0 is suppressed
    wr_en_in = 1'b1; wr_addr_in = 5'd0;
    cap("r0", 2'd0, 3'b000, 2'd0, 32'hDEAD_BEEF);
    chk("r0_wen", 32'(out_wr_en), 32'd0);
    wr_addr_in = 5'd7;

    // Drain
    in_valid = 1'b0;
    cyc();
    chk("drain_vld", 32'(out_valid), 32'd0);
    chk("drain_wen", 32'(out_wr_en), 32'd0);

    // Source not ready for three cycles
    set_src(3, 32'hA5A5_0001); sel = 2'd3; src_rdy = 4'b0111; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("srdy_stall", 32'(stall_req), 32'd1);
      cyc();
      chk("srdy_vld", 32'(out_valid), 32'd0);
    end
    src_rdy = 4'hF;
    #1;
    chk("srdy_go", 32'(stall_req), 32'd0);
    cyc();
    chk("srdy_vld4", 32'(out_valid), 32'd1);
    chk("srdy_data", out_data, 32'hA5A5_0001);
    chk("srdy_waddr", 32'(out_wr_addr), 32'd7);

    // Backpressure: hold, then replace in one edge
    set_src(0, 32'h1111_2222); sel = 2'd0; out_ready = 1'b0; wr_addr_in = 5'd9;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_inrdy", 32'(in_ready), 32'd0);
      chk("bp_stall", 32'(stall_req), 32'd1);
      cyc();
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_data", out_data, 32'hA5A5_0001);
      chk("bp_waddr", 32'(out_wr_addr), 32'd7);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_inrdy", 32'(in_ready), 32'd1);
    cyc();
    chk("bp_rep_vld", 32'(out_valid), 32'd1);
    chk("bp_rep_data", out_data, 32'h1111_2222);
    chk("bp_rep_waddr", 32'(out_wr_addr), 32'd9);

    // Flush with held entry and a new incoming one
    out_ready = 1'b0; flush = 1'b1; set_src(0, 32'h3333_4444);
    #1;
    chk("fl_inrdy", 32'(in_ready), 32'd0);
    chk("fl_stall", 32'(stall_req), 32'd0);
    cyc();
    chk("fl_vld", 32'(out_valid), 32'd0);
    chk("fl_wen", 32'(out_wr_en), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    chk("fl_nocap", 32'(out_valid), 32'd0);

    // Reset between edges while holding an entry
    in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    chk("rh_vld", 32'(out_valid), 32'd1);
    chk("rh_data", out_data, 32'h3333_4444);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rh_rst_vld", 32'(out_valid), 32'd0);
    chk("rh_rst_data", out_data, 32'd0);
    chk("rh_rst_wen", 32'(out_wr_en), 32'd0);
    #1 reset = 1'b0;
    in_valid = 1'b1; set_src(0, 32'h0BAD_F00D);
    cyc();
    chk("rh_first_vld", 32'(out_valid), 32'd1);
    chk("rh_first_data", out_data, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
